// File: rtl/pio_sched_pkg.sv
// Shared constants and types for the PIO sample scheduler: CSR map, CTRL/STATUS bit
// positions and the sampling FSM state encoding.
package pio_sched_pkg;

  localparam logic [1:0] CsrCtrl   = 2'd0;
  localparam logic [1:0] CsrPeriod = 2'd1;
  localparam logic [1:0] CsrStatus = 2'd2;
  localparam logic [1:0] CsrData   = 2'd3;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlClearBit  = 1;
  localparam int unsigned CtrlIrqEnBit  = 2;

  localparam int unsigned StatEmptyBit = 16;
  localparam int unsigned StatFullBit  = 17;
  localparam int unsigned StatOvfBit   = 31;

  // Shortest legal tick period; smaller PERIOD values are clamped to this.
  localparam int unsigned MinPeriod = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAddr,
    StCapt
  } sched_state_e;

endpackage

// File: rtl/pio_sample_fifo.sv
// Synchronous sample FIFO with flush; pointers carry an extra wrap bit so that full and
// empty are distinguished without a separate counter.
module pio_sample_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [Aw:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign level = wptr_q - rptr_q;
  assign rdata = mem[rptr_q[Aw-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/pio_sample_scheduler.sv
// Periodic PIO sampler with a CSR slave and sample FIFO.
// Define PIO_SCHED_CHANGE_ONLY_EN to push only samples that differ from the last pushed one.
module pio_sample_scheduler
  import pio_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        irq
);

  localparam int unsigned Lw = $clog2(FIFO_DEPTH) + 1;

  logic            enable_q, irq_en_q, ovf_q, irq_q;
  logic [31:0]     period_q, count_q, period_eff, rdata_q, status_word;
  sched_state_e    state_q;
  logic            ctrl_wr, clear, data_rd, tick, capt, push_req, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [Lw-1:0]   fifo_level;
  logic [31:0]     fifo_rdata;
  logic            unused_wdata;

  assign unused_wdata = ^csr_writedata[31:3];
  assign pio_address  = 2'd0;
  assign csr_readdata = rdata_q;
  assign irq          = irq_q;

  assign ctrl_wr    = csr_write && (csr_address == CsrCtrl);
  assign clear      = ctrl_wr && csr_writedata[CtrlClearBit];
  assign data_rd    = csr_read && (csr_address == CsrData);
  assign period_eff = (period_q < 32'(MinPeriod)) ? 32'(MinPeriod) : period_q;
  // >= rather than == so a PERIOD shrunk below the running count still wraps promptly.
  assign tick       = enable_q && (count_q >= period_eff);
  assign capt       = (state_q == StCapt) && enable_q && !clear;
  assign fifo_pop   = data_rd && !fifo_empty && !clear;

`ifdef PIO_SCHED_CHANGE_ONLY_EN
  logic [31:0] last_q;
  logic        last_valid_q;

  assign push_req = capt && (!last_valid_q || (pio_readdata != last_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else if (clear || !enable_q) begin
      last_valid_q <= 1'b0;
    end else if (push_req && (!fifo_full || fifo_pop)) begin
      last_q       <= pio_readdata;
      last_valid_q <= 1'b1;
    end
  end
`else
  assign push_req = capt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= csr_writedata[CtrlEnableBit];
        irq_en_q <= csr_writedata[CtrlIrqEnBit];
      end
      if (csr_write && (csr_address == CsrPeriod)) period_q <= csr_writedata;
      if (!enable_q || clear || tick) count_q <= '0;
      else                            count_q <= count_q + 32'd1;
      if (clear)                                     ovf_q <= 1'b0;
      else if (push_req && fifo_full && !fifo_pop)   ovf_q <= 1'b1;
      irq_q <= irq_en_q && !fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else if (clear) begin
      state_q <= csr_writedata[CtrlEnableBit] ? StWait : StIdle;
    end else if (!enable_q) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:  state_q <= StWait;
        StWait:  if (tick) state_q <= StAddr;
        StAddr:  state_q <= StCapt;
        StCapt:  state_q <= StWait;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    status_word               = '0;
    status_word[15:0]         = 16'(fifo_level);
    status_word[StatEmptyBit] = fifo_empty;
    status_word[StatFullBit]  = fifo_full;
    status_word[StatOvfBit]   = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (csr_read) begin
      case (csr_address)
        CsrCtrl:   rdata_q <= {29'd0, irq_en_q, 1'b0, enable_q};
        CsrPeriod: rdata_q <= period_q;
        CsrStatus: rdata_q <= status_word;
        default:   rdata_q <= (fifo_empty || clear) ? '0 : fifo_rdata;
      endcase
    end
  end

  pio_sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (clear),
    .push    (push_req),
    .pop     (data_rd),
    .wdata   (pio_readdata),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: doc/pio_sample_scheduler.md
# pio_sample_scheduler

Periodic sampling controller for the 32-bit Avalon-MM input PIO in the datalogger SoC. Reads the PIO data register at a programmable interval, buffers samples in an internal FIFO, and exposes a 4-word Avalon-MM CSR slave through which the HPS configures the interval and drains samples. An optional level interrupt signals pending data.

## Interface
- FIFO_DEPTH, 16: sample FIFO entries; power of two, 4..256.
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- pio_address  out  2  PIO address; constant 2'd0.
- pio_readdata  in  32  PIO readdata; registered in the PIO, valid one cycle after address.
- csr_address  in  2  CSR word address.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data; read latency 1.
- irq  out  1  level interrupt.

## Operation
- CSR map:
  - 0 CTRL: bit0 enable, bit1 clear (write-1 pulse, reads 0), bit2 irq_en.
  - 1 PERIOD: 32-bit.
  - 2 STATUS (RO): [15:0] fill level, bit16 empty, bit17 full, bit31 overflow (sticky).
  - 3 DATA (RO): read pops FIFO head; read when empty returns 0 and does not pop.
- Tick counter: counts 0..P, wraps to 0; tick asserted while count == P; P = max(PERIOD, 2). Held at 0 while disabled; zeroed on clear.
- FSM:
  - IDLE: enable=1 → WAIT.
  - WAIT: tick → ADDR.
  - ADDR: PIO registers in_port → CAPT.
  - CAPT: push pio_readdata → WAIT.
  - enable=0 in any state → IDLE next cycle; in-flight sample discarded.
- Push with FIFO full: sample dropped, overflow set; FIFO contents unchanged.
- Pop and push same cycle: both occur; level unchanged. Pop from full plus push: accepted, no overflow.
- Clear: flushes FIFO, clears overflow, zeroes counter; FSM → WAIT if enabled. Clear beats a same-cycle push; a same-cycle pop returns 0.
- PERIOD write takes effect at the next counter compare; no restart.
- irq = irq_en & !empty, registered.

## Timing
- Reset values: csr_readdata 0, irq 0, pio_address 0, CTRL 0, PERIOD 0, FIFO empty, overflow 0, counter 0, FSM IDLE.
- Sample interval exactly P+1 cycles.
- Tick in cycle T → ADDR in T+1 → PIO captures in_port at the edge ending T+1 → push at the edge ending T+2 → a STATUS/DATA read issued in T+3 sees it.
- CSR read: csr_readdata valid the cycle after csr_read and held until the next read. Pop committed at the edge ending the read cycle.
- Enable 0→1: counter starts at 0; first tick after P+1 cycles.

## Configuration
- PIO_SCHED_CHANGE_ONLY_EN defined:
  - CAPT pushes only if the sample differs from the last pushed value, or is the first sample since enable or clear.
  - Suppressed samples set neither overflow nor level.
  - Last-value register resets to 0 and is invalidated by enable or clear.
- Undefined: every captured sample is pushed; no last-value register.

## Structure
- Package pio_sched_pkg:
  - CSR address constants (CTRL, PERIOD, STATUS, DATA).
  - CTRL and STATUS bit-position constants.
  - FSM state enum (IDLE, WAIT, ADDR, CAPT).
- Sub-module pio_sample_fifo:
  - Synchronous FIFO: push, pop, flush, full, empty, level.
  - Pointers carry one extra wrap bit.
  - Instantiated once.

## Test plan
- PERIOD=9, enable, in_port ramps +1 per cycle from 0 → pushes every 10 cycles; values match the T+1 timing; STATUS level increments 1 per push.
- FIFO_DEPTH=16, PERIOD=2, no pops for 60 cycles → STATUS = 16 | full | overflow; 16 DATA reads return the first 16 samples in order, then empty; 17th read returns 0.
- Full FIFO, DATA read in the same cycle as CAPT → no overflow increment; level stays 16.
- Clear written during CAPT → FIFO empty, overflow 0, that sample absent; next push P+1 cycles later.
- Disable mid-ADDR, re-enable with PERIOD=0 → no push from the aborted sample; interval 3 cycles; irq rises one cycle after the first push when irq_en=1.
- With PIO_SCHED_CHANGE_ONLY_EN, in_port held at 0xA5A5_0001 for 5 ticks then 0x0000_0002 → exactly 2 entries. Without the macro → 6 entries.
